// File: rtl/tdm_mux8_tx_pkg.sv
// tdm_pkg: shared types and helpers for the TDM transmitter and the
// matching receiver-side capture block.
//   tdm_state_t      : frame FSM state (IDLE, SEND)
//   TDM_N_CH_DEFAULT : default channel count
//   slot_cnt_w()     : slot-counter width for a given slot length
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdm_state_t;

  localparam int TDM_N_CH_DEFAULT = 8;

  // Counter must hold 0..slot_cycles-1. A slot length of 1 still gets one bit
  // so the counter never collapses to zero width.
  function automatic int slot_cnt_w(input int slot_cycles);
    int w;
    w = $clog2(slot_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tdm_mux8_tx_if.sv
// tdm_mux8_tx_if: load handshake and serial TDM bus of the transmitter.
//   data_in/load : parallel word and load request (master -> slave)
//   ready        : transmitter idle, a load is accepted this edge
//   ser_out/sel/en : serial bit, channel index, slot active (to demux in/ctrl/en)
//   done         : one-cycle pulse after the last slot of a frame
interface tdm_mux8_tx_if
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH_DEFAULT
) ();
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]  data_in;
  logic             load;
  logic             ready;
  logic             ser_out;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             done;

  modport master (
    output data_in, load,
    input  ready, ser_out, sel, en, done
  );

  modport slave (
    input  data_in, load,
    output ready, ser_out, sel, en, done
  );
endinterface

// File: rtl/tdm_mux8_tx_slot_timer.sv
// tdm_slot_timer: counts clocks within one TDM slot.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count back to 0 (used while idle)
//   run      : advance the count this edge
//   slot_end : high on the terminal-count cycle (count = SLOT_CYCLES-1 and run)
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic slot_end
);
  localparam int CW = slot_cnt_w(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign slot_end = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (run)     cnt <= slot_end ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: time-division transmitter feeding the 8-channel demux.
// Captures data_in on load&&ready, then drives channel i's bit on ser_out with
// sel=i and en=1 for SLOT_CYCLES clocks each, channels 0..N_CH-1 in order,
// followed by one IDLE cycle carrying the done pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tdm_mux8_tx_if slave (data_in, load, ready, ser_out, sel, en, done)
// All outputs are registered.
module tdm_mux8_tx
  import tdm_pkg::*;
#(
  parameter int N_CH        = TDM_N_CH_DEFAULT,
  parameter int SLOT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  tdm_mux8_tx_if.slave  bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  tdm_state_t       state_q, state_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel_nxt;
  logic             ser_q, ser_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             slot_end;

  tdm_slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .run      (state_q == SEND),
    .slot_end (slot_end)
  );

  assign sel_nxt = sel_q + SEL_W'(1);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    ser_d    = ser_q;
    en_d     = en_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        en_d    = 1'b0;
        ser_d   = 1'b0;
        sel_d   = '0;
        if (bus.load && ready_q) begin
          shadow_d = bus.data_in;
          ser_d    = bus.data_in[0];
          en_d     = 1'b1;
          ready_d  = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (slot_end) begin
          if (sel_q == SEL_LAST) begin
            // sel returns to 0 only via IDLE, never wraps inside a frame
            en_d    = 1'b0;
            ser_d   = 1'b0;
            sel_d   = '0;
            ready_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            sel_d = sel_nxt;
            ser_d = shadow_q[sel_nxt];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sel_q    <= '0;
      ser_q    <= 1'b0;
      en_q     <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      ser_q    <= ser_d;
      en_q     <= en_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.ser_out = ser_q;
  assign bus.sel     = sel_q;
  assign bus.en      = en_q;
  assign bus.done    = done_q;
endmodule

// File: doc/tdm_mux8_tx.md
Name: tdm_mux8_tx

Overview:
- Time-division transmitter for the 8-channel demultiplexer: the sending end of its `in/en/ctrl` interface.
- Captures an 8-bit parallel word on a load handshake, then scans channels 0..7 in order.
- For each channel it drives the channel's bit on `ser_out`, the channel index on `sel` and `en` high, each held for `SLOT_CYCLES` clocks.
- Sits upstream of the demux; its `ser_out/en/sel` connect directly to the demux `in/en/ctrl` ports.

Parameters:
- N_CH, 8, number of channels; power of two, minimum 2.
- SEL_W, $clog2(N_CH), width of `sel`; derived, not overridden.
- SLOT_CYCLES, 4, clocks each channel is held; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  N_CH  parallel word; bit i goes to channel i.
- load  in  1  request to transmit `data_in`; accepted only when `ready`=1.
- ready  out  1  high in IDLE; a load is accepted on an edge where load=1 and ready=1.
- ser_out  out  1  serial data; holds the shadow bit of the current channel.
- sel  out  SEL_W  current channel index; drives the demux ctrl.
- en  out  1  high while a channel slot is active.
- done  out  1  single-cycle pulse after the last slot of a frame.

Behaviour:
- All outputs are registered.
- Reset values:
  - ready=1, en=0, sel=0, ser_out=0, done=0.
  - Shadow register=0, slot counter=0, state=IDLE.
- rst asserted mid-frame: all outputs return to reset values at that edge; the frame is discarded and no done pulse is produced.
- States: IDLE, SEND.
- IDLE:
  - ready=1, en=0, ser_out=0, sel=0.
  - On an edge with load=1: shadow<=data_in, slot counter<=0, sel<=0, ser_out<=data_in[0], en<=1, ready<=0, state<=SEND.
- SEND:
  - Slot counter counts 0..SLOT_CYCLES-1 on each edge.
  - At terminal count with sel<N_CH-1: sel<=sel+1, ser_out<=shadow[sel+1], counter<=0.
  - At terminal count with sel=N_CH-1: en<=0, ser_out<=0, sel<=0, ready<=1, done<=1, state<=IDLE.
- done is high for exactly one cycle, the first IDLE cycle. A load accepted in that cycle starts the next frame; done still deasserts on the next edge.
- Timing, load sampled at edge k:
  - Channel i is driven in cycles k+1+i*S through k+(i+1)*S, where S=SLOT_CYCLES.
  - done and ready are high in cycle k+1+N_CH*S.
  - Frame occupies N_CH*S cycles.
  - Minimum load-to-load spacing is N_CH*S+1 cycles.
- load while ready=0 is ignored and never queued. data_in changes during SEND have no effect; the shadow is stable for the whole frame.
- SLOT_CYCLES=1: sel advances on every edge; a frame is 8 cycles plus one IDLE cycle.
- `sel` wraps only through the IDLE return, never 7->0 inside SEND.
- Simultaneous rst and load: rst wins, load is dropped.

Decomposition:
- Package `tdm_pkg`:
  - State enum `tdm_state_t` {IDLE, SEND}.
  - Constant `TDM_N_CH_DEFAULT`=8.
  - Function for the slot-counter width, $clog2(SLOT_CYCLES) with a floor of 1.
- Sub-module `tdm_slot_timer`:
  - Parameter SLOT_CYCLES; inputs clk, rst, clear, run; output `slot_end`.
  - `slot_end` is high on the terminal-count cycle.
  - Reused by the matching receiver-side capture block.
- Top level keeps the FSM, the shadow register and the sel/ser_out datapath.

Test Plan:
- Reset: assert rst 3 cycles -> ready=1, en=0, sel=0, ser_out=0, done=0. Assert rst at cycle 10 of a frame -> same values at the next edge, no done pulse.
- Single frame, SLOT_CYCLES=4, data_in=8'b1010_0101, load 1 cycle:
  - sel steps 0..7, each value held exactly 4 cycles.
  - ser_out=1,0,1,0,0,1,0,1 for channels 0..7.
  - en high for 32 cycles.
  - done=1 in cycle 33 after load, for 1 cycle.
- Loopback through the demux with data_in=8'hC3: demux output j pulses high during slot j only for j in {0,1,6,7}.
- Load ignored while busy:
  - load=1 with data_in=8'hFF at cycle 5 of a frame carrying 8'h00 -> ser_out stays 0 for the whole frame, no second frame starts.
  - data_in changed mid-frame -> output unchanged.
- Back-to-back, SLOT_CYCLES=1: load 8'h0F, then load 8'hF0 in the done cycle.
  - Frame 1: ser_out=1,1,1,1,0,0,0,0.
  - One IDLE cycle with done=1, en=0.
  - Frame 2: ser_out=0,0,0,0,1,1,1,1.
  - Exactly 2 done pulses.
